// File: rtl/bat_register_bank_if.sv
// rtl/bat_register_bank_if.sv - strobe, bus and OUT-stream signals of the register bank
interface bat_register_bank_if #(
  parameter int WIDTH     = 8,
  parameter int OUT_DEPTH = 4
);
  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

  logic [7:0]       REGS_INC;
  logic [7:0]       REGS_RW;
  logic [7:0]       REGS_EN;
  logic [WIDTH-1:0] BUS_IN;
  logic [WIDTH-1:0] BUS_OUT;
  logic             BUS_DRIVE;
  logic             BUS_CONFLICT;
  logic [WIDTH-1:0] REG_A;
  logic [WIDTH-1:0] REG_B;
  logic [WIDTH-1:0] OUT_DATA;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic             OUT_OVERRUN;
  logic [CNT_W-1:0] OUT_COUNT;

  // Controller / consumer side
  modport master (
    output REGS_INC, REGS_RW, REGS_EN, BUS_IN, OUT_READY,
    input  BUS_OUT, BUS_DRIVE, BUS_CONFLICT, REG_A, REG_B,
    input  OUT_DATA, OUT_VALID, OUT_OVERRUN, OUT_COUNT
  );

  // Register bank side
  modport slave (
    input  REGS_INC, REGS_RW, REGS_EN, BUS_IN, OUT_READY,
    output BUS_OUT, BUS_DRIVE, BUS_CONFLICT, REG_A, REG_B,
    output OUT_DATA, OUT_VALID, OUT_OVERRUN, OUT_COUNT
  );
endinterface

// File: rtl/bat_register_bank.sv
// rtl/bat_register_bank.sv - eight bus registers with increment, conflict flag and OUT FIFO
module bat_register_bank #(
  parameter int WIDTH     = 8,
  parameter int OUT_DEPTH = 4
) (
  input logic               CLK,
  input logic               RST,
  bat_register_bank_if.slave bus
);
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_regs [8];
  logic [WIDTH-1:0] r_mem  [OUT_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_conflict;
  logic             r_overrun;

  logic [7:0]       w_readers;
  logic [7:0]       w_loads;
  logic [7:0]       w_incs;
  logic             w_conflict;
  logic [WIDTH-1:0] w_bus_out;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_push_ok;
  logic [WIDTH-1:0] w_r7_next;

  assign w_readers  = bus.REGS_EN & bus.REGS_RW;
  assign w_loads    = bus.REGS_EN & ~bus.REGS_RW;
  assign w_incs     = ~bus.REGS_EN & ~bus.REGS_RW & bus.REGS_INC;
  // Two or more readers: clearing the lowest set bit leaves something behind
  assign w_conflict = (w_readers & (w_readers - 8'd1)) != 8'd0;

  // Lowest-indexed reader wins the bus; nothing is driven when no register reads
  always_comb begin
    w_bus_out = '0;
    for (int i = 7; i >= 0; i--) begin
      if (w_readers[i]) w_bus_out = r_regs[i];
    end
  end

  assign bus.BUS_OUT   = w_bus_out;
  assign bus.BUS_DRIVE = |w_readers;

  // OUT pushes whatever value R7 takes on this edge
  assign w_r7_next = w_loads[7] ? bus.BUS_IN : r_regs[7] + WIDTH'(1);
  assign w_push    = w_loads[7] | w_incs[7];
  assign w_pop     = (r_count != '0) & bus.OUT_READY;
  assign w_full    = (r_count == CNT_W'(OUT_DEPTH));
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push
  assign w_push_ok = w_push & (~w_full | w_pop);

  // Register file: load beats read beats increment, else hold
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_loads[i])     r_regs[i] <= bus.BUS_IN;
        else if (w_incs[i]) r_regs[i] <= r_regs[i] + WIDTH'(1);
      end
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_conflict <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_conflict) r_conflict <= 1'b1;
      if (w_push && w_full && !w_pop) r_overrun <= 1'b1;
    end
  end

  // OUT FIFO storage and pointers; pointers wrap naturally at power-of-two depth
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < OUT_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= w_r7_next;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.BUS_CONFLICT = r_conflict;
  assign bus.OUT_OVERRUN  = r_overrun;
  assign bus.REG_A        = r_regs[0];
  assign bus.REG_B        = r_regs[1];
  assign bus.OUT_VALID    = (r_count != '0);
  assign bus.OUT_DATA     = (r_count != '0) ? r_mem[r_rptr] : '0;
  assign bus.OUT_COUNT    = r_count;
endmodule
